branch_pht: RTL

Pattern history table for the RV32I fetch stage: an array of 2-bit saturating counters indexed by PC, optionally gshare-hashed with a global history register. Fetch reads a taken/not-taken prediction combinationally. When a branch resolves in execute, the indexed counter is read, stepped, and written back, and the global history is shifted. The block owns the counter state and the next-state update for every counter.

---
 rtl/branch_pht_if.sv | 25 ++
 rtl/branch_pht.sv | 99 +++++++++
 2 files changed

// File: rtl/branch_pht_if.sv
// Fetch/execute side of the pattern history table: prediction lookup, branch
// resolution update, table clear, and the debug/statistics outputs.
interface branch_pht_if #(
    parameter int INDEX_BITS = 6
) ();
    logic [31:0]           pred_pc;
    logic                  pred_taken;
    logic [INDEX_BITS-1:0] pred_idx;
    logic                  upd_valid;
    logic [INDEX_BITS-1:0] upd_idx;
    logic                  upd_taken;
    logic                  tbl_clear;
    logic [INDEX_BITS-1:0] ghr;
    logic [31:0]           mispredict_cnt;

    modport master (
        output pred_pc, upd_valid, upd_idx, upd_taken, tbl_clear,
        input  pred_taken, pred_idx, ghr, mispredict_cnt
    );

    modport slave (
        input  pred_pc, upd_valid, upd_idx, upd_taken, tbl_clear,
        output pred_taken, pred_idx, ghr, mispredict_cnt
    );
endinterface

// File: rtl/branch_pht.sv
// Pattern history table of 2-bit saturating counters, optionally gshare-indexed,
// with a global history register and a saturating misprediction counter.
module branch_pht #(
    parameter int         INDEX_BITS = 6,
    parameter bit         GSHARE     = 1'b1,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic         clk,
    input  logic         rst_n,
    branch_pht_if.slave  bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            pht_r [ENTRIES];
    logic [INDEX_BITS-1:0] ghr_r;
    logic [31:0]           mispredict_cnt_r;

    logic [INDEX_BITS-1:0] pc_bits_s;
    logic [INDEX_BITS-1:0] pred_idx_s;
    logic [1:0]            upd_ctr_s;
    logic [1:0]            next_ctr_s;
    logic                  upd_en_s;
    logic                  mispredict_s;
    logic                  unused_pc_s;

    // Saturating 2-bit counter step; never wraps at either end.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case (ctr)
            2'b00:   nxt = taken ? 2'b01 : 2'b00;
            2'b01:   nxt = taken ? 2'b10 : 2'b00;
            2'b10:   nxt = taken ? 2'b11 : 2'b01;
            2'b11:   nxt = taken ? 2'b11 : 2'b10;
            default: nxt = INIT_STATE;
        endcase
        return nxt;
    endfunction

    // Prediction index: word-aligned PC bits, hashed with history when gshare is enabled.
    always_comb begin
        pc_bits_s = bus.pred_pc[INDEX_BITS+1:2];
        if (GSHARE) begin
            pred_idx_s = pc_bits_s ^ ghr_r;
        end else begin
            pred_idx_s = pc_bits_s;
        end
    end

    assign unused_pc_s = ^{bus.pred_pc[31:INDEX_BITS+2], bus.pred_pc[1:0]};

    // Resolution path: a clear discards any update arriving in the same cycle.
    always_comb begin
        upd_ctr_s    = pht_r[bus.upd_idx];
        next_ctr_s   = ctr_step(upd_ctr_s, bus.upd_taken);
        upd_en_s     = bus.upd_valid & ~bus.tbl_clear;
        mispredict_s = upd_ctr_s[1] ^ bus.upd_taken;
    end

    // Counter array: reset/clear to INIT_STATE, otherwise write back the stepped counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_r[i] <= INIT_STATE;
            end
        end else if (bus.tbl_clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_r[i] <= INIT_STATE;
            end
        end else if (upd_en_s) begin
            pht_r[bus.upd_idx] <= next_ctr_s;
        end
    end

    // Global history: newest outcome shifts in at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_r <= {INDEX_BITS{1'b0}};
        end else if (bus.tbl_clear) begin
            ghr_r <= {INDEX_BITS{1'b0}};
        end else if (upd_en_s) begin
            ghr_r <= {ghr_r[INDEX_BITS-2:0], bus.upd_taken};
        end
    end

    // Misprediction statistics survive a table clear and stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_cnt_r <= 32'd0;
        end else if (upd_en_s && mispredict_s && (mispredict_cnt_r != 32'hFFFF_FFFF)) begin
            mispredict_cnt_r <= mispredict_cnt_r + 32'd1;
        end
    end

    assign bus.pred_idx       = pred_idx_s;
    assign bus.pred_taken     = pht_r[pred_idx_s][1];
    assign bus.ghr            = ghr_r;
    assign bus.mispredict_cnt = mispredict_cnt_r;

endmodule
